sm_trace_buffer: RTL

- Hardware commit-trace capture stage. Sits directly downstream of the CPU core (sm_cpu) and consumes the same per-cycle state the simulation trace prints: pc, instr, a0.
- Records one entry per CPU step into an on-chip FIFO. Stops on a cycle limit or a PC breakpoint.
- Drains entries as a stream of 32-bit words over a valid/ready port, for a debug UART or host bridge.
- Gives FPGA builds the same "cycle / pc / instr / a0 / Timeout" visibility as simulation.

---
 rtl/sm_trace_buffer.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/sm_trace_buffer.sv
// Commit-trace capture: records {cycle, pc, instr, a0} per CPU step into a FIFO
// and streams each entry out as four 32-bit words over valid/ready.
module sm_trace_buffer #(
    parameter int DEPTH      = 16,
    parameter int MAX_CYCLES = 120
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       cpu_step,
    input  logic [31:0]                pc,
    input  logic [31:0]                instr,
    input  logic [31:0]                a0,
    input  logic                       arm,
    input  logic                       bp_en,
    input  logic [31:0]                bp_pc,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [31:0]                out_data,
    output logic                       out_last,
    output logic                       capturing,
    output logic                       done,
    output logic                       timeout,
    output logic                       bp_hit,
    output logic                       overflow,
    output logic [$clog2(DEPTH):0]     level
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    typedef enum logic [1:0] {IDLE, CAPTURE, DONE} state_t;

    state_t        state, stateNext;
    logic [31:0]   memCycle [DEPTH];
    logic [31:0]   memPc    [DEPTH];
    logic [31:0]   memInstr [DEPTH];
    logic [31:0]   memA0    [DEPTH];
    logic [AW-1:0] wrPtr, rdPtr;
    logic [LW-1:0] levelReg;
    logic [1:0]    wordIdx;
    logic [31:0]   cycle, cycleNext;
    logic          timeoutReg, bpHitReg, overflowReg;
    logic          flush, stepCap, push, pop, handshake, full, empty, bpMatch, limitHit;

    assign cycleNext = cycle + 32'd1;
    assign bpMatch   = bp_en && (pc == bp_pc);
    assign limitHit  = (cycleNext == 32'(MAX_CYCLES));
    // Fullness uses the registered level, so a same-cycle pop never rescues a write
    assign full      = (levelReg == LW'(DEPTH));
    assign empty     = (levelReg == '0);
    assign push      = stepCap && !full;
    assign handshake = !empty && out_ready;
    assign pop       = handshake && (wordIdx == 2'd3);

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= stateNext;
    end

    always_comb begin
        stateNext = state;
        flush     = 1'b0;
        stepCap   = 1'b0;
        case (state)
            IDLE, DONE: begin
                if (arm) begin
                    stateNext = CAPTURE;
                    flush     = 1'b1;
                end
            end
            CAPTURE: begin
                if (cpu_step) begin
                    stepCap = 1'b1;
                    if (bpMatch || limitHit) stateNext = DONE;
                end
            end
            default: stateNext = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wrPtr       <= '0;
            rdPtr       <= '0;
            levelReg    <= '0;
            wordIdx     <= '0;
            cycle       <= '0;
            timeoutReg  <= 1'b0;
            bpHitReg    <= 1'b0;
            overflowReg <= 1'b0;
        end else if (flush) begin
            // Flush also discards a partially drained head entry
            wrPtr       <= '0;
            rdPtr       <= '0;
            levelReg    <= '0;
            wordIdx     <= '0;
            cycle       <= '0;
            timeoutReg  <= 1'b0;
            bpHitReg    <= 1'b0;
            overflowReg <= 1'b0;
        end else begin
            if (push) wrPtr <= wrPtr + AW'(1);
            if (handshake) begin
                wordIdx <= wordIdx + 2'd1;
                if (pop) rdPtr <= rdPtr + AW'(1);
            end
            case ({push, pop})
                2'b10:   levelReg <= levelReg + LW'(1);
                2'b01:   levelReg <= levelReg - LW'(1);
                default: levelReg <= levelReg;
            endcase
            if (stepCap) begin
                cycle <= cycleNext;
                if (bpMatch)  bpHitReg    <= 1'b1;
                if (limitHit) timeoutReg  <= 1'b1;
                if (full)     overflowReg <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            memCycle[wrPtr] <= cycle;
            memPc[wrPtr]    <= pc;
            memInstr[wrPtr] <= instr;
            memA0[wrPtr]    <= a0;
        end
    end

    always_comb begin
        out_data = '0;
        if (!empty) begin
            case (wordIdx)
                2'd0:    out_data = memCycle[rdPtr];
                2'd1:    out_data = memPc[rdPtr];
                2'd2:    out_data = memInstr[rdPtr];
                default: out_data = memA0[rdPtr];
            endcase
        end
    end

    assign out_valid = !empty;
    assign out_last  = !empty && (wordIdx == 2'd3);
    assign capturing = (state == CAPTURE);
    assign done      = (state == DONE);
    assign timeout   = timeoutReg;
    assign bp_hit    = bpHitReg;
    assign overflow  = overflowReg;
    assign level     = levelReg;

endmodule
